// File: rtl/aes_pkg.sv
// Shared Rijndael state geometry: legal block widths, per-row shift offsets, byte positions.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int NB_LEGAL_CNT = 3;
    localparam logic [NB_LEGAL_CNT-1:0][7:0] NB_LEGAL = {8'd4, 8'd6, 8'd8};

    function automatic bit nb_is_legal(input int nb);
        for (int i = 0; i < NB_LEGAL_CNT; i++) begin
            if (int'(NB_LEGAL[i]) == nb) return 1'b1;
        end
        return 1'b0;
    endfunction

    // 256-bit blocks use the wider 1/3/4 offsets; 128- and 192-bit blocks use 1/2/3.
    function automatic int shift_offset(input int nb, input int r);
        if (r == 0) return 0;
        if (nb == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    // Byte (c, r) is byte index 4c+r, packed MSB-first across the state vector.
    function automatic int byte_lsb(input int nb, input int c, input int r);
        return 32 * nb - 8 - 8 * (4 * c + r);
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation, selected by inv.
// Latency: 0 cycles (pure wiring plus a 2:1 mux per byte).
// Backpressure: none; no state.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic             inv,
    input  logic [32*NB-1:0] state,
    output logic [32*NB-1:0] shifted
);

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int S   = shift_offset(NB, r);
            localparam int FWD = (c + S) % NB;
            localparam int BWD = (c - S + NB) % NB;

            assign shifted[byte_lsb(NB, c, r) +: 8] = inv ? state[byte_lsb(NB, BWD, r) +: 8]
                                                          : state[byte_lsb(NB, FWD, r) +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_stream.sv
// Pipelined ShiftRows/InvShiftRows with tag + mode sideband; SHIFT_ROWS_STREAM_IN_REG_EN adds an input register.
// Latency: 1 cycle (2 with SHIFT_ROWS_STREAM_IN_REG_EN).
// Backpressure: output reg + 1-entry skid; in_ready is a flop, low only when the skid (and input reg) is full.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [32*NB-1:0] in_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_state,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_inv
);

    if (!nb_is_legal(NB)) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shift_rows_stream: TAG_W must be at least 1");
    end

    typedef struct packed {
        logic             inv;
        logic [TAG_W-1:0] tag;
        logic [32*NB-1:0] state;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    occ_t             occ_q, occ_d;
    entry_t           in_entry, be_dat, perm_entry, out_q, skid_q;
    logic             be_vld, be_rdy, push, pop;
    logic             load_out, load_skid, skid_to_out;
    logic             in_ready_q, in_ready_nxt;
    logic [32*NB-1:0] perm_state;

    assign in_entry = {in_inv, in_tag, in_state};

`ifdef SHIFT_ROWS_STREAM_IN_REG_EN
    entry_t stage_q;
    logic   stage_vld_q, stage_vld_d, in_push;

    assign in_push     = in_valid && in_ready_q;
    assign be_rdy      = (occ_q != FULL);
    assign be_vld      = stage_vld_q;
    assign be_dat      = stage_q;
    assign stage_vld_d = in_push || (stage_vld_q && !be_rdy);
    // Stall only when the input register is stuck behind a full skid next cycle.
    assign in_ready_nxt = !(stage_vld_d && (occ_d == FULL));

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld_q <= 1'b0;
            stage_q     <= '0;
        end else begin
            stage_vld_q <= stage_vld_d;
            if (in_push) stage_q <= in_entry;
        end
    end
`else
    assign be_vld       = in_valid;
    assign be_dat       = in_entry;
    assign be_rdy       = in_ready_q;
    assign in_ready_nxt = (occ_d != FULL);
`endif

    shift_rows_perm #(.NB(NB)) u_perm (
        .inv     (be_dat.inv),
        .state   (be_dat.state),
        .shifted (perm_state)
    );

    assign perm_entry = {be_dat.inv, be_dat.tag, perm_state};
    assign push       = be_vld && be_rdy;
    assign pop        = out_valid && out_ready;

    always_comb begin
        occ_d       = occ_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (occ_q)
            EMPTY: begin
                if (push) begin
                    occ_d    = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_out = 1'b1;
                end else if (push) begin
                    occ_d     = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    occ_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    occ_d       = ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            in_ready_q <= in_ready_nxt;
            if (load_out) out_q <= perm_entry;
            else if (skid_to_out) out_q <= skid_q;
            if (load_skid) skid_q <= perm_entry;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != EMPTY);
    assign out_state = out_q.state;
    assign out_tag   = out_q.tag;
    assign out_inv   = out_q.inv;

endmodule

// File: doc/shift_rows_stream.md
Name: shift_rows_stream

Overview:
- Parametrised, pipelined Rijndael ShiftRows / InvShiftRows engine with a valid/ready streaming interface.
- A per-transaction mode bit selects the forward or inverse permutation.
- Supports Rijndael block widths Nb = 4, 6 or 8 columns. Nb = 4 is AES.
- Sits between SubBytes/InvSubBytes and MixColumns/InvMixColumns in the iterative round datapath. A sideband tag travels with each state.

Parameters:
- NB, 4, number of 32-bit state columns. Legal values: 4, 6, 8. Any other value is an elaboration-time error.
- TAG_W, 4, width of the opaque sideband tag (round number / context ID). Minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input state is valid.
- in_ready  output  1  block can accept an input this cycle.
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows.
- in_tag  input  TAG_W  sideband tag, passed through unmodified.
- in_state  input  32*NB  state, column-major, MSB-first.
- out_valid  output  1  output state is valid.
- out_ready  input  1  downstream accepts the output.
- out_state  output  32*NB  permuted state.
- out_tag  output  TAG_W  tag associated with out_state.
- out_inv  output  1  mode bit associated with out_state.

Behaviour:
- Interface decision: one clock (clk); rst is synchronous and active-high.
- Byte layout:
  - Byte index b = 4*c + r, where c is the column and r is the row.
  - Byte b occupies bits [32*NB-1-8b -: 8].
- Row offsets s(r):
  - r0 = 0 for all NB.
  - NB = 4 or 6: r1 = 1, r2 = 2, r3 = 3.
  - NB = 8: r1 = 1, r2 = 3, r3 = 4.
- Forward permutation: out[r][c] = in[r][(c + s(r)) mod NB].
- Inverse permutation: out[r][c] = in[r][(c - s(r)) mod NB], with non-negative modulo.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Datapath structure: combinational permute, then a main output register, backed by a 1-entry skid register. Total capacity is 2 entries.
- Latency: 1 cycle from input transfer to out_valid, when the output stage is empty or draining.
- Throughput: 1 state per cycle under continuous out_ready.
- in_ready is registered, equal to !skid_full. It is never combinationally derived from out_ready.
- Occupancy FSM states:
  - EMPTY: out_valid = 0, skid empty.
  - ONE: out_valid = 1, skid empty.
  - FULL: out_valid = 1, skid holding data, in_ready = 0.
- Transitions:
  - EMPTY to ONE on input transfer.
  - ONE to EMPTY on output transfer with no input.
  - ONE stays ONE on simultaneous input and output transfer.
  - ONE to FULL on input transfer without output transfer. The permuted data goes to skid.
  - FULL to ONE on output transfer. Skid moves into the output register.
  - No input is accepted in FULL, even if out_ready = 1 in the same cycle.
- Stability: while out_valid && !out_ready, out_state, out_tag and out_inv hold stable.
- Ordering: strict FIFO order. Mode and tag stay bound to their own state.
- Reset:
  - out_valid = 0, in_ready = 1 in the cycle after rst is asserted.
  - out_state, out_tag, out_inv and skid contents reset to 0.
  - FSM returns to EMPTY.
  - In-flight states are discarded mid-operation; no partial output is produced.
- Row 0 is never moved. Bytes are never modified, only relocated.

Optional Feature:
- Macro: SHIFT_ROWS_STREAM_IN_REG_EN.
- Defined:
  - Adds a registered input stage ahead of the permutation, giving 2-cycle latency.
  - Total capacity becomes 3 entries. in_ready remains registered.
  - Throughput remains 1 per cycle.
  - Reset clears the extra stage's valid bit.
- Undefined: 1-cycle latency as described above.

Decomposition:
- Package aes_pkg holds:
  - the function shift_offset(nb, r) returning s(r);
  - the function byte_lsb(nb, c, r) returning a bit position;
  - the localparam list of legal NB values.
- One natural sub-module, shift_rows_perm:
  - purely combinational;
  - parameter NB; inputs inv and state; output state.
  - It is instantiated once ahead of the output register.

Test Plan:
- NB = 4, inv = 0, in_state = 0x000102030405060708090a0b0c0d0e0f, out_ready = 1 -> one cycle later out_state = 0x00050a0f04090e03080d02070c01060b.
- NB = 4, inv = 1, same in_state -> out_state = 0x000d0a0704010e0b0805020f0c090603. Round-trip: forward then inverse returns the original input.
- Streaming: 8 back-to-back states with alternating inv and tags 0..7, out_ready = 1 -> 8 outputs on 8 consecutive cycles, in order, tags and modes matched.
- Backpressure: out_ready = 0 for 5 cycles while in_valid = 1 -> exactly 2 states accepted, in_ready = 0 after the 2nd, out_state stable. Releasing out_ready drains both in order with no loss or duplication.
- NB = 8 forward with byte-counting input -> row2 shifted by 3 and row3 by 4. Example: out col0 row3 = byte 0x13 (c = 4, r = 3). NB = 6 checked against a reference model over 1000 random states in both modes.
- Reset asserted while FULL -> next cycle out_valid = 0, in_ready = 1. First post-reset input appears alone, with no stale data.
